huffman_frame_ctrl: RTL

//  Frame sequencer for the huffman core. Buffers one frame of FRAME_LEN gray symbols (values 1..6) from a

---
 rtl/huffman_frame_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/huffman_frame_ctrl.sv
// Frame sequencer for the huffman core: buffers one frame of gray symbols, pulses the core
// reset, bursts the frame gap-free, then collects count/code tables and reports done or error.
module huffman_frame_ctrl #(
    parameter int FRAME_LEN = 100,
    parameter int CRST_CYC  = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        core_rst,
    output logic        core_gray_valid,
    output logic [7:0]  core_gray_data,
    input  logic        core_cnt_valid,
    input  logic        core_code_valid,
    input  logic [47:0] core_cnt,
    input  logic [47:0] core_hc,
    input  logic [47:0] core_m,
    output logic [47:0] cnt_tbl,
    output logic [47:0] hc_tbl,
    output logic [47:0] m_tbl
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CRST, S_BURST, S_WAIT_CODE, S_DONE, S_ERR
    } state_t;

    localparam logic [6:0]  LAST_IDX   = 7'(FRAME_LEN - 1);
    localparam logic [3:0]  CRST_LAST  = 4'(CRST_CYC - 1);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  frame_buf [FRAME_LEN];
    logic [6:0]  wr_ptr, rd_ptr, rd_ptr_inc;
    logic [3:0]  crst_cnt;
    logic [15:0] timer;
    logic        cnt_seen;
    logic        accept, sym_ok, code_ok, cnt_capture;

    assign accept      = in_valid && (state == S_LOAD);
    assign sym_ok      = (in_data >= 8'd1) && (in_data <= 8'd6);
    // A count arriving in the same cycle as the code still counts as "seen".
    assign code_ok     = core_code_valid && (cnt_seen || core_cnt_valid);
    assign cnt_capture = core_cnt_valid && ((state == S_BURST) || (state == S_WAIT_CODE));
    assign rd_ptr_inc  = rd_ptr + 7'd1;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        err       = (state == S_ERR);
        in_ready  = (state == S_LOAD);
        core_rst  = (state == S_IDLE) || (state == S_CRST) || (state == S_ERR);
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (accept) begin
                    if (!sym_ok)                 state_nxt = S_ERR;
                    else if (wr_ptr == LAST_IDX) state_nxt = S_CRST;
                end
            end
            S_CRST:  if (crst_cnt == CRST_LAST) state_nxt = S_BURST;
            S_BURST: if (rd_ptr == LAST_IDX)    state_nxt = S_WAIT_CODE;
            S_WAIT_CODE: begin
                if (core_code_valid)           state_nxt = code_ok ? S_DONE : S_ERR;
                else if (timer == TIMER_LAST)  state_nxt = S_ERR;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Symbol storage is never reset; every frame refills it from index 0.
    always_ff @(posedge clk) begin
        if (accept && sym_ok) frame_buf[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            crst_cnt        <= '0;
            timer           <= '0;
            cnt_seen        <= 1'b0;
            err_code        <= 2'd0;
            core_gray_valid <= 1'b0;
            core_gray_data  <= 8'd0;
            cnt_tbl         <= '0;
            hc_tbl          <= '0;
            m_tbl           <= '0;
        end else begin
            if (cnt_capture) begin
                cnt_tbl  <= core_cnt;
                cnt_seen <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_code <= 2'd0;
                        wr_ptr   <= '0;
                        cnt_seen <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (!sym_ok) begin
                            err_code <= 2'd1;
                        end else begin
                            wr_ptr <= wr_ptr + 7'd1;
                            if (wr_ptr == LAST_IDX) crst_cnt <= '0;
                        end
                    end
                end
                S_CRST: begin
                    crst_cnt <= crst_cnt + 4'd1;
                    // Preload the first symbol so the burst lines up with the BURST state.
                    if (crst_cnt == CRST_LAST) begin
                        rd_ptr          <= '0;
                        core_gray_valid <= 1'b1;
                        core_gray_data  <= frame_buf[0];
                    end
                end
                S_BURST: begin
                    if (rd_ptr == LAST_IDX) begin
                        core_gray_valid <= 1'b0;
                        core_gray_data  <= 8'd0;
                        timer           <= '0;
                    end else begin
                        rd_ptr         <= rd_ptr_inc;
                        core_gray_data <= frame_buf[rd_ptr_inc];
                    end
                end
                S_WAIT_CODE: begin
                    timer <= timer + 16'd1;
                    if (code_ok) begin
                        hc_tbl <= core_hc;
                        m_tbl  <= core_m;
                    end else if (core_code_valid) begin
                        err_code <= 2'd3;
                    end else if (timer == TIMER_LAST) begin
                        err_code <= 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
